// File: rtl/seg_scan_pkg.sv
// Shared types, constants and helpers for the 7-segment scan controller.
// Optional feature macro: DIMMING_EN (adds per-slot brightness control).
package seg_scan_pkg;

  localparam int unsigned MAX_DIGITS = 8;
  localparam int unsigned SEG_W      = 8;

  typedef enum logic {
    S_BLANK = 1'b0,
    S_ON    = 1'b1
  } scan_state_e;

  localparam logic [SEG_W-1:0] SEG_BLANK = 8'h00;
  localparam logic [SEG_W-1:0] SEG_ERR   = 8'h02;

  // Segment glyphs {a,b,c,d,e,f,g,dp}; non-BCD codes show a dash.
  localparam logic [SEG_W-1:0] GLYPH_TBL [16] = '{
    8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
    8'hFE, 8'hF6, SEG_ERR, SEG_ERR, SEG_ERR, SEG_ERR, SEG_ERR, SEG_ERR
  };

  // Active-low one-hot select; digit idx maps to bit (width-1-idx).
  function automatic logic [MAX_DIGITS-1:0] com_onehot_n(input logic [2:0] idx,
                                                         input int unsigned width);
    logic [MAX_DIGITS-1:0] res;
    res = '1;
    res[3'(width - 32'd1 - 32'(idx))] = 1'b0;
    return res;
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Host/pin bundle of the scan controller; slave side is the controller.
interface seg_scan_ctrl_if #(
  parameter int unsigned NUM_DIGITS = 8
) ();

  logic                      upd_req;
  logic [4*NUM_DIGITS-1:0]   upd_data;
  logic [NUM_DIGITS-1:0]     digit_en;
`ifdef DIMMING_EN
  logic [3:0]                bright;
`endif
  logic                      upd_ack;
  logic                      frame_tick;
  logic [NUM_DIGITS-1:0]     seg_com;
  logic [7:0]                seg_data;

  modport master (
    output upd_req, upd_data, digit_en,
`ifdef DIMMING_EN
    output bright,
`endif
    input  upd_ack, frame_tick, seg_com, seg_data
  );

  modport slave (
    input  upd_req, upd_data, digit_en,
`ifdef DIMMING_EN
    input  bright,
`endif
    output upd_ack, frame_tick, seg_com, seg_data
  );

endinterface

// File: rtl/seg_glyph_dec.sv
// Combinational BCD nibble to 7-segment pattern lookup.
module seg_glyph_dec
  import seg_scan_pkg::*;
(
  input  logic [3:0]       bcd,
  output logic [SEG_W-1:0] seg_c
);

  // Table lookup; codes 10..15 resolve to the error dash.
  assign seg_c = GLYPH_TBL[bcd];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan scheduler for an N-digit common-cathode display.
// Each slot: blank gap then lit window; digit store is double-buffered and
// host updates commit only at frame end.
// Optional feature macro: DIMMING_EN (input bright shortens the lit window).
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 8,
  parameter int unsigned SCAN_DIV   = 1000,
  parameter int unsigned BLANK_CYC  = 16
) (
  input logic            clk,
  input logic            rst,
  seg_scan_ctrl_if.slave bus
);

  localparam int unsigned CNT_W  = $clog2(SCAN_DIV);
  localparam int unsigned IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned DATA_W = 4 * NUM_DIGITS;
  localparam int unsigned ON_CYC = SCAN_DIV - BLANK_CYC;

  scan_state_e             state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [IDX_W-1:0]        idx_q;
  logic [DATA_W-1:0]       active_q;
  logic [DATA_W-1:0]       shadow_q;
  logic                    pending_q;
  logic                    upd_ack_q;
  logic                    frame_tick_q;
  logic [NUM_DIGITS-1:0]   seg_com_q;
  logic [SEG_W-1:0]        seg_data_q;

  logic                    slot_end_c;
  logic                    last_slot_c;
  logic                    blank_end_c;
  logic [3:0]              cur_bcd_c;
  logic                    cur_en_c;
  logic [SEG_W-1:0]        glyph_c;
  logic [MAX_DIGITS-1:0]   com_c;
  logic                    dim_lit_c;
  logic                    lit_c;
  logic                    commit_c;

  assign slot_end_c  = (cnt_q == CNT_W'(SCAN_DIV - 1));
  assign last_slot_c = (idx_q == IDX_W'(NUM_DIGITS - 1));
  assign blank_end_c = (cnt_q == CNT_W'(BLANK_CYC - 1));

  // Select the active nibble and enable bit of the current slot.
  always_comb begin
    cur_bcd_c = 4'h0;
    cur_en_c  = 1'b0;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_bcd_c = active_q[4*i +: 4];
        cur_en_c  = bus.digit_en[i];
      end
    end
  end

  seg_glyph_dec u_glyph_dec (
    .bcd   (cur_bcd_c),
    .seg_c (glyph_c)
  );

  assign com_c = com_onehot_n(3'(idx_q), NUM_DIGITS);

`ifdef DIMMING_EN
  logic [3:0]  bright_q;
  logic [31:0] lit_len_c;
  logic [31:0] on_k_c;

  assign lit_len_c = ((32'(bright_q) + 32'd1) * ON_CYC) >> 4;
  assign on_k_c    = 32'(cnt_q) - BLANK_CYC;
  assign dim_lit_c = (on_k_c < lit_len_c);

  // Brightness is frozen for a slot at its blank-to-lit transition.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bright_q <= 4'h0;
    end else if ((state_q == S_BLANK) && blank_end_c) begin
      bright_q <= bus.bright;
    end
  end
`else
  assign dim_lit_c = 1'b1;
`endif

  assign lit_c    = (state_q == S_ON) && cur_en_c && dim_lit_c;
  assign commit_c = frame_tick_q && (pending_q || bus.upd_req);

  // Slot counter, digit index and blank/on phase FSM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_BLANK;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      if (slot_end_c) begin
        cnt_q <= '0;
        idx_q <= last_slot_c ? '0 : idx_q + IDX_W'(1);
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      case (state_q)
        S_BLANK: if (blank_end_c) state_q <= S_ON;
        S_ON:    if (slot_end_c)  state_q <= S_BLANK;
        default: state_q <= S_BLANK;
      endcase
    end
  end

  // Shadow capture and frame-boundary commit; a request landing on the
  // commit cycle bypasses the shadow so the newest data wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      active_q  <= '0;
      shadow_q  <= '0;
      pending_q <= 1'b0;
      upd_ack_q <= 1'b0;
    end else begin
      upd_ack_q <= commit_c;
      if (frame_tick_q) begin
        pending_q <= 1'b0;
        if (bus.upd_req) begin
          active_q <= bus.upd_data;
          shadow_q <= bus.upd_data;
        end else if (pending_q) begin
          active_q <= shadow_q;
        end
      end else if (bus.upd_req) begin
        shadow_q  <= bus.upd_data;
        pending_q <= 1'b1;
      end
    end
  end

  // Pin registers: one cycle behind the scan position.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_tick_q <= 1'b0;
      seg_com_q    <= '1;
      seg_data_q   <= SEG_BLANK;
    end else begin
      frame_tick_q <= slot_end_c && last_slot_c;
      seg_com_q    <= lit_c ? com_c[NUM_DIGITS-1:0] : '1;
      seg_data_q   <= lit_c ? glyph_c : SEG_BLANK;
    end
  end

  assign bus.upd_ack    = upd_ack_q;
  assign bus.frame_tick = frame_tick_q;
  assign bus.seg_com    = seg_com_q;
  assign bus.seg_data   = seg_data_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl (4 digits, 8-cycle slots, 2 blank).
module tb_seg_scan_ctrl;

  localparam int N     = 4;
  localparam int DIV   = 8;
  localparam int BLK   = 2;
  localparam int FRAME = N * DIV;
  localparam int ONC   = DIV - BLK;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  seg_scan_ctrl_if #(.NUM_DIGITS(N)) bus ();

  seg_scan_ctrl #(
    .NUM_DIGITS (N),
    .SCAN_DIV   (DIV),
    .BLANK_CYC  (BLK)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] glyph [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                             8'hFE, 8'hF6, 8'h02, 8'h02, 8'h02, 8'h02, 8'h02, 8'h02};

  // Reference model state: position in the frame is edges since reset.
  int         ecount;
  logic [15:0] m_active, m_shadow;
  bit         m_pending;
`ifdef DIMMING_EN
  int         m_bright;
`endif
  logic [3:0] e_com;
  logic [7:0] e_data;
  bit         e_ack, e_ft;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, ecount);
    end
  endtask

  // Behavioural model: pins after an edge show the frame position that edge closed.
  always @(posedge clk or negedge rst) begin : model
    int p, slot, c;
    bit lit, commit;
    if (!rst) begin
      ecount    = 0;
      m_active  = '0;
      m_shadow  = '0;
      m_pending = 0;
`ifdef DIMMING_EN
      m_bright  = 0;
`endif
      e_com  = 4'hF;
      e_data = 8'h00;
      e_ack  = 0;
      e_ft   = 0;
    end else begin
      p    = ecount % FRAME;
      slot = p / DIV;
      c    = p % DIV;
      lit  = (c >= BLK) && (bus.digit_en[slot] == 1'b1);
`ifdef DIMMING_EN
      if (c >= BLK && (c - BLK) >= ((m_bright + 1) * ONC) / 16) lit = 0;
      if (c == BLK - 1) m_bright = int'(bus.bright);
`endif
      e_com  = lit ? ~(4'b0001 << (N - 1 - slot)) : 4'hF;
      e_data = lit ? glyph[m_active[slot*4 +: 4]] : 8'h00;
      commit = e_ft && (m_pending || bus.upd_req);
      if (e_ft) begin
        if (bus.upd_req) begin
          m_active = bus.upd_data;
          m_shadow = bus.upd_data;
        end else if (m_pending) begin
          m_active = m_shadow;
        end
        m_pending = 0;
      end else if (bus.upd_req) begin
        m_shadow  = bus.upd_data;
        m_pending = 1;
      end
      e_ack  = commit;
      e_ft   = (p == FRAME - 1);
      ecount = ecount + 1;
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(posedge clk) begin
    #1;
    check("seg_com",    32'(bus.seg_com),    32'(e_com));
    check("seg_data",   32'(bus.seg_data),   32'(e_data));
    check("upd_ack",    32'(bus.upd_ack),    32'(e_ack));
    check("frame_tick", 32'(bus.frame_tick), 32'(e_ft));
  end

  task automatic go(input int target);
    int guard = 0;
    while (ecount < target && guard < 4000) begin
      @(negedge clk);
      guard++;
    end
    if (ecount != target) begin
      vectors++;
      miscompares++;
      $display("FAIL go: reached edge %0d expected %0d", ecount, target);
    end
  endtask

  task automatic pulse_req(input logic [15:0] d);
    bus.upd_req  = 1'b1;
    bus.upd_data = d;
    @(negedge clk);
    bus.upd_req  = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.upd_req  = 1'b0;
    bus.upd_data = '0;
    bus.digit_en = 4'hF;
`ifdef DIMMING_EN
    bus.bright   = 4'd15;
`endif
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_com",  32'(bus.seg_com),    32'hF);
    check("rst_data", 32'(bus.seg_data),   32'h00);
    check("rst_ack",  32'(bus.upd_ack),    32'h0);
    check("rst_ft",   32'(bus.frame_tick), 32'h0);
    rst = 1'b1;

    // Free-running scan from reset with blank buffers.
    go(1);  check("blank0", 32'(bus.seg_com), 32'hF);
    go(3);  check("slot0_com", 32'(bus.seg_com), 32'h7);
            check("slot0_data", 32'(bus.seg_data), 32'hFC);
    go(11); check("slot1_com", 32'(bus.seg_com), 32'hB);
    go(19); check("slot2_com", 32'(bus.seg_com), 32'hD);
    go(27); check("slot3_com", 32'(bus.seg_com), 32'hE);
    go(31); check("ft_early", 32'(bus.frame_tick), 32'h0);
    go(32); check("ft_on", 32'(bus.frame_tick), 32'h1);
    go(33); check("ft_off", 32'(bus.frame_tick), 32'h0);
            check("blank_after_ft", 32'(bus.seg_com), 32'hF);

    // Mid-frame update commits only at frame end.
    go(40); pulse_req(16'h4321);
    go(60); check("no_tear", 32'(bus.seg_data), 32'hFC);
    go(64); check("ack_wait", 32'(bus.upd_ack), 32'h0);
    go(65); check("ack_4321", 32'(bus.upd_ack), 32'h1);
    go(66); check("ack_single", 32'(bus.upd_ack), 32'h0);
    go(67); check("show_1", 32'(bus.seg_data), 32'h60);
    go(91); check("show_4", 32'(bus.seg_data), 32'h66);

    // Two requests in one frame: latest wins, one ack.
    go(100); pulse_req(16'h1111);
    go(105); pulse_req(16'h9999);
    go(129); check("ack_9999", 32'(bus.upd_ack), 32'h1);
    go(130); check("ack_9999_once", 32'(bus.upd_ack), 32'h0);
    go(131); check("show_9_s0", 32'(bus.seg_data), 32'hF6);
    go(155); check("show_9_s3", 32'(bus.seg_data), 32'hF6);

    // Request on the commit cycle itself.
    go(160); check("ft_160", 32'(bus.frame_tick), 32'h1);
             pulse_req(16'h5678);
    check("ack_coinc", 32'(bus.upd_ack), 32'h1);
    go(163); check("show_8", 32'(bus.seg_data), 32'hFE);
    go(171); check("show_7", 32'(bus.seg_data), 32'hE0);

    // Disabled slots stay dark; non-BCD nibble shows the dash.
    go(180); bus.digit_en = 4'b1010; pulse_req(16'hA5A0);
    go(195); check("dis_s0_com", 32'(bus.seg_com), 32'hF);
             check("dis_s0_data", 32'(bus.seg_data), 32'h00);
    go(203); check("en_s1_com", 32'(bus.seg_com), 32'hB);
             check("err_s1", 32'(bus.seg_data), 32'h02);
    go(211); check("dis_s2_com", 32'(bus.seg_com), 32'hF);
    go(219); check("en_s3_com", 32'(bus.seg_com), 32'hE);
             check("err_s3", 32'(bus.seg_data), 32'h02);

`ifdef DIMMING_EN
    go(224); bus.bright = 4'd7;
    go(237); check("dim_lit", 32'(bus.seg_com), 32'hB);
    go(238); check("dim_dark", 32'(bus.seg_com), 32'hF);
    bus.bright = 4'd15;
`endif

    // Randomised traffic checked by the model.
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      bus.upd_req  = ($urandom_range(0, 19) == 0);
      bus.upd_data = 16'($urandom);
      if ($urandom_range(0, 15) == 0) bus.digit_en = 4'($urandom);
`ifdef DIMMING_EN
      bus.bright = 4'($urandom);
`endif
    end
    @(negedge clk);
    bus.upd_req  = 1'b0;
    bus.digit_en = 4'hF;
`ifdef DIMMING_EN
    bus.bright   = 4'd15;
`endif

    // Reset mid-slot with a pending update discards it.
    begin
      int guard = 0;
      while ((ecount % FRAME) != 10 && guard < 100) begin
        @(negedge clk);
        guard++;
      end
    end
    pulse_req(16'h7777);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mrst_com",  32'(bus.seg_com),    32'hF);
    check("mrst_data", 32'(bus.seg_data),   32'h00);
    check("mrst_ack",  32'(bus.upd_ack),    32'h0);
    check("mrst_ft",   32'(bus.frame_tick), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    go(3);  check("post_rst_data", 32'(bus.seg_data), 32'hFC);
    go(33); check("post_rst_ack", 32'(bus.upd_ack), 32'h0);
    go(35); check("post_rst_buf", 32'(bus.seg_data), 32'hFC);
    go(40);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
